// File: rtl/stream_decryptor.sv
// Byte-serial stream-cipher decryptor: XORs incoming words with a Geffe-combined
// keystream from three LFSRs (5/7/9 bit), one bit per cycle, LSB first.
module stream_decryptor #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           key_load,
  input  logic [20:0]    key,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           keyed,
  output logic           busy
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned L5W = 5;
  localparam int unsigned L7W = 7;
  localparam int unsigned L9W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [L5W-1:0]   l5_q, l5_d;
  logic [L7W-1:0]   l7_q, l7_d;
  logic [L9W-1:0]   l9_q, l9_d;
  logic [W-1:0]     data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             keyed_q, keyed_d;
  logic             out_valid_q, out_valid_d;

  logic             ks_bit;
  logic [W:0]       shift_ext;
  logic [L5W-1:0]   seed5;
  logic [L7W-1:0]   seed7;
  logic [L9W-1:0]   seed9;

  assign seed5 = key[4:0];
  assign seed7 = key[11:5];
  assign seed9 = key[20:12];

  // Geffe combiner taken from the current (pre-step) LFSR state
  assign ks_bit = l5_q[0] ? l7_q[0] : l9_q[0];

  // Result bit enters at the MSB so the first bit processed ends up at bit 0
  assign shift_ext = {data_q[0] ^ ks_bit, data_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      l5_q        <= '0;
      l7_q        <= '0;
      l9_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      keyed_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      l5_q        <= l5_d;
      l7_q        <= l7_d;
      l9_q        <= l9_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      keyed_q     <= keyed_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    l5_d        = l5_q;
    l7_d        = l7_q;
    l9_d        = l9_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    keyed_d     = keyed_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;

    if (key_load) begin
      // All-zero sub-seeds would lock their LFSR, so they load as all-ones
      l5_d        = (seed5 == '0) ? '1 : seed5;
      l7_d        = (seed7 == '0) ? '1 : seed7;
      l9_d        = (seed9 == '0) ? '1 : seed9;
      keyed_d     = 1'b1;
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready = keyed_q;
          if (in_valid && keyed_q) begin
            data_d  = in_data;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          data_d = shift_ext[W:1];
          l5_d   = {l5_q[L5W-2:0], l5_q[4] ^ l5_q[2]};
          l7_d   = {l7_q[L7W-2:0], l7_q[6] ^ l7_q[5]};
          l9_d   = {l9_q[L9W-2:0], l9_q[8] ^ l9_q[4]};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign keyed     = keyed_q;
  assign busy      = (state_q == RUN) || (state_q == OUT);

endmodule

// File: tb/tb_stream_decryptor.sv
// Self-checking bench for stream_decryptor: scoreboard of model-encrypted words
// checked against DUT output, plus reset, backpressure, zero-seed and abort scenarios.
module tb_stream_decryptor;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_load;
  logic [20:0]   key;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          keyed;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [4:0]    m5;
  logic [6:0]    m7;
  logic [8:0]    m9;
  logic [W-1:0]  exp_q[$];

  stream_decryptor #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_load (key_load),
    .key      (key),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .keyed    (keyed),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_seed(input logic [20:0] k);
    m5 = (k[4:0]   == 5'd0) ? 5'h1f  : k[4:0];
    m7 = (k[11:5]  == 7'd0) ? 7'h7f  : k[11:5];
    m9 = (k[20:12] == 9'd0) ? 9'h1ff : k[20:12];
  endtask

  task automatic model_word(input logic [W-1:0] c, output logic [W-1:0] p);
    logic kb;
    p = '0;
    for (int i = 0; i < W; i++) begin
      kb   = m5[0] ? m7[0] : m9[0];
      p[i] = c[i] ^ kb;
      m5   = {m5[3:0], m5[4] ^ m5[2]};
      m7   = {m7[5:0], m7[6] ^ m7[5]};
      m9   = {m9[7:0], m9[8] ^ m9[4]};
    end
  endtask

  // Called at a negedge; returns at a negedge with key_load released
  task automatic key_cmd(input logic [20:0] k);
    key      = k;
    key_load = 1'b1;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL key_load_priority: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    key_load = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (keyed !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL key_load_state: keyed=%b busy=%b out_valid=%b required 1/0/0",
               keyed, busy, out_valid);
    end
    model_seed(k);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_word(input logic [W-1:0] c, output int acc_edge);
    logic [W-1:0] p;
    bit done;
    done     = 1'b0;
    acc_edge = -1;
    in_valid = 1'b1;
    in_data  = c;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (in_ready === 1'b1) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      acc_edge = cyc + 1;
      model_word(c, p);
      exp_q.push_back(p);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  task automatic wait_out(output logic [W-1:0] d, output int out_edge, output bit ok);
    ok       = 1'b0;
    d        = '0;
    out_edge = -1;
    for (int i = 0; i < 4 * W + 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok       = 1'b1;
        d        = out_data;
        out_edge = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    key_load  = 1'b0;
    key       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (keyed !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: keyed=%b in_ready=%b out_valid=%b out_data=%h busy=%b required all 0",
               keyed, in_ready, out_valid, out_data, busy);
    end
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5a;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || keyed !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL unkeyed_idle: in_ready=%b out_valid=%b keyed=%b busy=%b required 0",
                 in_ready, out_valid, keyed, busy);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_known_vector;
    logic [W-1:0] d, e;
    int t, te;
    bit ok;
    key_cmd(21'h001021);
    send_word(8'h00, t);
    wait_out(d, te, ok);
    e = exp_q.pop_front();
    if (ok) begin
      checks++;
      if (d !== 8'h41) begin
        errors++;
        $display("FAIL kv_encrypt: out_data=%h required 41", d);
      end
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL kv_model: out_data=%h required %h", d, e);
      end
      checks++;
      if (te !== t + W) begin
        errors++;
        $display("FAIL kv_latency: out_valid at edge %0d required %0d", te, t + W);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL kv_consumed: out_valid=%b busy=%b required 0/0", out_valid, busy);
    end
    key_cmd(21'h001021);
    send_word(8'h41, t);
    wait_out(d, te, ok);
    e = exp_q.pop_front();
    if (ok) begin
      checks++;
      if (d !== 8'h00 || d !== e) begin
        errors++;
        $display("FAIL kv_decrypt: out_data=%h required 00", d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] words[16];
    logic [W-1:0] p, e;
    int n_acc, n_out, last_acc;
    for (int i = 0; i < 16; i++) words[i] = W'($urandom);
    key_cmd(21'($urandom));
    n_acc    = 0;
    n_out    = 0;
    last_acc = -1;
    for (int c = 0; c < 16 * (W + 2) + 60; c++) begin
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        n_out++;
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL b2b_data[%0d]: out_data=%h required %h", n_out - 1, out_data, e);
        end
      end
      if (n_acc < 16) begin
        in_valid = 1'b1;
        in_data  = words[n_acc];
        #1;
        if (in_ready === 1'b1) begin
          model_word(words[n_acc], p);
          exp_q.push_back(p);
          if (last_acc >= 0) begin
            checks++;
            if (cyc + 1 - last_acc !== W + 2) begin
              errors++;
              $display("FAIL b2b_spacing[%0d]: spacing=%0d required %0d",
                       n_acc, cyc + 1 - last_acc, W + 2);
            end
          end
          last_acc = cyc + 1;
          n_acc++;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (n_out == 16) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (n_out !== 16) begin
      errors++;
      $display("FAIL b2b_count: words out=%0d required 16", n_out);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [W-1:0] d, e, held;
    int t, te;
    bit ok, bad;
    key_cmd(21'h0a5c3e);
    out_ready = 1'b0;
    send_word(8'hc3, t);
    wait_out(d, te, ok);
    held = d;
    bad  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || busy !== 1'b1)
        bad = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: out_valid=%b out_data=%h in_ready=%b required 1/%h/0",
               out_valid, out_data, in_ready, held);
    end
    e = exp_q.pop_front();
    checks++;
    if (held !== e) begin
      errors++;
      $display("FAIL bp_word0: out_data=%h required %h", held, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    send_word(8'h3c, t);
    wait_out(d, te, ok);
    e = exp_q.pop_front();
    if (ok) begin
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL bp_word1: out_data=%h required %h", d, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_seed;
    logic [W-1:0] d, e;
    int t, te;
    bit ok;
    key_cmd(21'h000000);
    send_word(8'h96, t);
    wait_out(d, te, ok);
    e = exp_q.pop_front();
    if (ok) begin
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL zero_seed: out_data=%h required %h", d, e);
      end
    end
    @(negedge clk);
    key_cmd(21'h1fffff);
    send_word(8'h96, t);
    wait_out(d, te, ok);
    e = exp_q.pop_front();
    if (ok) begin
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL ones_seed: out_data=%h required %h", d, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic [W-1:0] d, e;
    int t, te;
    bit ok, bad;
    key_cmd(21'h13579b);
    send_word(8'ha5, t);
    repeat (2) @(negedge clk);
    key_cmd(21'h02468a);
    exp_q.delete();
    bad = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_key_drop: out_valid=%b busy=%b required 0/0", out_valid, busy);
    end
    send_word(8'h5a, t);
    wait_out(d, te, ok);
    e = exp_q.pop_front();
    if (ok) begin
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL abort_key_next: out_data=%h required %h", d, e);
      end
    end
    @(negedge clk);

    send_word(8'hf0, t);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (keyed !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL abort_reset: keyed=%b busy=%b out_valid=%b out_data=%h required 0",
               keyed, busy, out_valid, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || keyed !== 1'b0) begin
      errors++;
      $display("FAIL abort_rekey_needed: in_ready=%b keyed=%b required 0/0", in_ready, keyed);
    end
    in_valid = 1'b0;
    @(negedge clk);
    key_cmd(21'h1c0de5);
    send_word(8'h0f, t);
    wait_out(d, te, ok);
    e = exp_q.pop_front();
    if (ok) begin
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL abort_reset_next: out_data=%h required %h", d, e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_backpressure();
    test_zero_seed();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
